// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN activation datapath: default word width,
// default sigmoid latency and the requester tag carried alongside each operand.
package cnn_pkg;

   localparam int CNN_DATA_WIDTH  = 32;
   localparam int CNN_SIG_LATENCY = 4;
   localparam int TAG_ID_W        = 3;   // wide enough for up to 8 requesters

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/cnn_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// with wrap; the pointer register itself lives in the parent.
module cnn_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      grant_idx,
   output logic               grant_any,
   output logic [PW-1:0]      next_ptr
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
      next_ptr = ptr;
      if (grant_any)
         next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PW'(1);
   end

endmodule

// File: rtl/cnn_sigmoid_arbiter.sv
// Shares one fixed-latency sigmoid among NUM_REQ requesters: round-robin issue,
// ID tag pipe matched to the sigmoid latency, result routing and frame counting.
module cnn_sigmoid_arbiter
   import cnn_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
   parameter int SIG_LATENCY = CNN_SIG_LATENCY,
   parameter int FRAME_LEN   = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          sig_valid_in,
   output logic [DATA_WIDTH-1:0]         sig_in,
   input  logic                          sig_valid_out,
   input  logic [DATA_WIDTH-1:0]         sig_out,
   output logic [DATA_WIDTH-1:0]         out,
   output logic [NUM_REQ-1:0]            valid_out,
   output logic [NUM_REQ-1:0]            done,
   output logic                          err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   logic [ID_W-1:0]       ptr_reg, ptr_next;
   logic [ID_W-1:0]       grant_idx;
   logic                  grant_any;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       issue_id_reg;
   tag_t                  tag_pipe_reg [SIG_LATENCY];
   tag_t                  tail_reg;
   logic                  ret_hit;
   logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
   logic [NUM_REQ-1:0]    frame_hit, frame_end;
   logic [CNT_W-1:0]      cnt_reg [NUM_REQ];

   cnn_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(ID_W)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any),
      .next_ptr  (ptr_next)
   );

   assign req_ready = grant;
   assign ret_hit   = sig_valid_out && tail_reg.vld;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_word[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign frame_hit[gi] = ret_hit && (tail_reg.id == TAG_ID_W'(gi));
         assign frame_end[gi] = frame_hit[gi] && (cnt_reg[gi] == CNT_W'(FRAME_LEN - 1));

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               cnt_reg[gi] <= '0;
            else if (frame_end[gi])
               cnt_reg[gi] <= '0;
            else if (frame_hit[gi])
               cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg      <= '0;
         sig_valid_in <= 1'b0;
         sig_in       <= '0;
         issue_id_reg <= '0;
         for (int k = 0; k < SIG_LATENCY; k++)
            tag_pipe_reg[k] <= '0;
         tail_reg     <= '0;
         out          <= '0;
         valid_out    <= '0;
         done         <= '0;
         err          <= 1'b0;
      end else begin
         ptr_reg      <= ptr_next;
         sig_valid_in <= grant_any;
         if (grant_any) begin
            sig_in       <= req_word[grant_idx];
            issue_id_reg <= grant_idx;
         end

         // Entry 0 is captured on the sigmoid's sampling edge; the tail stage
         // lines up with the cycle its result is presented.
         tag_pipe_reg[0] <= '{vld: sig_valid_in, id: TAG_ID_W'(issue_id_reg)};
         for (int k = 1; k < SIG_LATENCY; k++)
            tag_pipe_reg[k] <= tag_pipe_reg[k-1];
         tail_reg <= tag_pipe_reg[SIG_LATENCY-1];

         valid_out <= '0;
         done      <= frame_end;
         if (ret_hit) begin
            out       <= sig_out;
            valid_out <= NUM_REQ'(1) << tail_reg.id;
         end
         if (sig_valid_out != tail_reg.vld)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cnn_sigmoid_arbiter.sv
// Randomized bench: a round-robin reference model predicts grants and results,
// a monitor pops the scoreboard whenever the DUT returns a result.
module tb_cnn_sigmoid_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int L  = 4;
   localparam int FL = 4;
   localparam logic [DW-1:0] SIGC = 32'h3F00_0000;

   typedef struct {
      int              t;
      int              id;
      logic [DW-1:0]   d;
      bit              done;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            sig_valid_in;
   logic [DW-1:0]   sig_in;
   logic            sig_valid_out;
   logic [DW-1:0]   sig_out;
   logic [DW-1:0]   out;
   logic [N-1:0]    valid_out;
   logic [N-1:0]    done;
   logic            err;
   logic            inject = 1'b0;

   cnn_sigmoid_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .SIG_LATENCY(L), .FRAME_LEN(FL)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .sig_valid_in(sig_valid_in), .sig_in(sig_in),
      .sig_valid_out(sig_valid_out), .sig_out(sig_out),
      .out(out), .valid_out(valid_out), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in sigmoid: samples valid_in, answers L cycles later with a marked word
   logic [L:0]    sv_sh;
   logic [DW-1:0] sd_sh [L+1];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sv_sh <= '0;
         for (int k = 0; k <= L; k++) sd_sh[k] <= '0;
      end else begin
         sv_sh    <= {sv_sh[L-1:0], sig_valid_in};
         sd_sh[0] <= sig_in ^ SIGC;
         for (int k = 1; k <= L; k++) sd_sh[k] <= sd_sh[k-1];
      end
   end
   assign sig_valid_out = sv_sh[L] | inject;
   assign sig_out       = sd_sh[L];

   int            errors = 0;
   int            checks = 0;
   exp_t          sb[$];
   int            m_ptr = 0;
   int            m_cnt [N];
   logic [N-1:0]  want = '0;
   logic [DW-1:0] dat [N];
   bit            err_exp = 1'b0;
   bit            mon_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One cycle of stimulus: present requests, predict grant, record expectation
   task automatic drive();
      int g;
      logic [N-1:0] exp_rdy;
      exp_t e;
      req_valid = want;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
      #1;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && want[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = (g < 0) ? '0 : (N'(1) << g);
      check("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
         m_cnt[g]++;
         e.t    = cyc + 1 + 2 + L;
         e.id   = g;
         e.d    = dat[g] ^ SIGC;
         e.done = (m_cnt[g] == FL);
         if (e.done) m_cnt[g] = 0;
         sb.push_back(e);
         want[g] = 1'b0;
         m_ptr   = (g + 1) % N;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      want = '0;
      while (sb.size() > 0 && n < 40) begin
         drive();
         n++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      drive();
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_valid_out", valid_out, '0);
      check("rst_done", done, '0);
      check("rst_sig_valid_in", sig_valid_in, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_out", out, '0);
      check("rst_sig_in", sig_in, '0);
      sb.delete();
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      err_exp = 1'b0;
      want    = '0;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en && !reset) begin
         if (valid_out != '0) begin
            if (sb.size() == 0) begin
               check("spurious_valid_out", valid_out, '0);
            end else begin
               e = sb.pop_front();
               $display("result cyc=%0d id=%0d out=%h done=%b", cyc, e.id, out, done);
               check("valid_out", valid_out, N'(1) << e.id);
               check("out", out, e.d);
               check("done", done, e.done ? (N'(1) << e.id) : '0);
               check("latency", 64'(cyc), 64'(e.t));
            end
         end else begin
            if (done != '0) check("done_idle", done, '0);
            if (sb.size() > 0 && cyc > sb[0].t) begin
               e = sb.pop_front();
               check("missing_result", 64'(cyc), 64'(e.t));
            end
         end
         check("err", err, err_exp);
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         dat[i]   = '0;
      end
      @(negedge clk);
      @(negedge clk);
      check("init_valid_out", valid_out, '0);
      check("init_sig_valid_in", sig_valid_in, 1'b0);
      check("init_err", err, 1'b0);
      check("init_req_ready", req_ready, '0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Lone requester 0 with 0.0
      dat[0] = '0;
      want[0] = 1'b1;
      drive();
      drain();

      // All requesters continuously valid
      repeat (40) begin
         for (int i = 0; i < N; i++)
            if (!want[i]) begin
               want[i] = 1'b1;
               dat[i]  = $urandom;
            end
         drive();
      end
      drain();

      // Requester 1 withdraws while requester 3 holds
      do_reset();
      dat[0] = $urandom; dat[1] = $urandom; dat[3] = $urandom;
      want = 4'b0011;
      drive();
      want[1] = 1'b0;
      want[3] = 1'b1;
      drive();
      want = 4'b1111;
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      drive();
      drain();

      // Random mix with legal withdrawals
      repeat (400) begin
         for (int i = 0; i < N; i++) begin
            if (!want[i] && ($urandom_range(0, 1) == 1)) begin
               want[i] = 1'b1;
               dat[i]  = $urandom;
            end else if (want[i] && ($urandom_range(0, 9) == 0)) begin
               want[i] = 1'b0;
            end
         end
         drive();
      end
      drain();

      // Requester 2 only across a frame boundary
      do_reset();
      repeat (8) begin
         want[2] = 1'b1;
         dat[2]  = $urandom;
         drive();
      end
      drain();

      // Spurious sigmoid result with an empty tag pipe
      inject = 1'b1;
      @(posedge clk);
      #1 err_exp = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      repeat (6) drive();
      check("err_sticky", err, 1'b1);

      // Reset with three operands in flight
      do_reset();
      for (int i = 0; i < 3; i++) dat[i] = $urandom;
      want = 4'b0111;
      repeat (3) drive();
      do_reset();
      repeat (12) drive();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
